// File: rtl/bnn_pkg.sv
// Shared types and width helpers for the BNN layer blocks.
package bnn_pkg;

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_OUTPUT  = 2'd3
    } layer_state_t;

    // Bits needed to index n items (at least 1).
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Bits needed to hold a count from 0 to max_val inclusive.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/xnor_popcount.sv
// Combinational XNOR of a weight beat with an activation beat, then popcount.
module xnor_popcount
    import bnn_pkg::*;
#(
    parameter int unsigned BEAT_BITS = 64
) (
    input  logic [BEAT_BITS-1:0]           w,
    input  logic [BEAT_BITS-1:0]           x,
    output logic [cnt_width(BEAT_BITS)-1:0] count
);

    localparam int unsigned PC_W = cnt_width(BEAT_BITS);

    logic [BEAT_BITS-1:0] match;

    assign match = w ~^ x;

    // Count matching bit positions.
    always_comb begin
        count = '0;
        for (int i = 0; i < int'(BEAT_BITS); i++) begin
            count = count + PC_W'(match[i]);
        end
    end

endmodule

// File: rtl/bnn_layer_seq.sv
// Sequencer for one binary fully-connected layer: buffers an input vector,
// streams weights/thresholds through a shared XNOR-popcount unit per neuron,
// and emits the packed activation vector on a valid/ready stream.
module bnn_layer_seq
    import bnn_pkg::*;
#(
    parameter int unsigned NUM_INPUTS     = 256,
    parameter int unsigned BEAT_BITS      = 64,
    parameter int unsigned NUM_NEURONS    = 64,
    parameter int unsigned THRESHOLD_BITS = 32
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic                                             in_valid,
    output logic                                             in_ready,
    input  logic [BEAT_BITS-1:0]                             in_data,
    output logic                                             w_rd_en,
    output logic [idx_width(NUM_NEURONS*(NUM_INPUTS/BEAT_BITS))-1:0] w_addr,
    input  logic [BEAT_BITS-1:0]                             w_rd_data,
    output logic                                             th_rd_en,
    output logic [idx_width(NUM_NEURONS)-1:0]                th_addr,
    input  logic [THRESHOLD_BITS-1:0]                        th_rd_data,
    output logic                                             out_valid,
    input  logic                                             out_ready,
    output logic [NUM_NEURONS-1:0]                           out_data,
    output logic                                             busy
);

    localparam int unsigned BEATS = NUM_INPUTS / BEAT_BITS;
    localparam int unsigned AW    = idx_width(NUM_NEURONS * BEATS);
    localparam int unsigned NW    = idx_width(NUM_NEURONS);
    localparam int unsigned BW    = idx_width(BEATS);
    localparam int unsigned ACC_W = cnt_width(NUM_INPUTS);
    localparam int unsigned PC_W  = cnt_width(BEAT_BITS);
    localparam int unsigned CMP_W = (ACC_W > THRESHOLD_BITS) ? ACC_W : THRESHOLD_BITS;

    localparam logic [BW-1:0] B_LAST = BW'(BEATS - 1);
    localparam logic [NW-1:0] N_LAST = NW'(NUM_NEURONS - 1);

    if ((NUM_INPUTS % BEAT_BITS) != 0) begin : g_bad_cfg
        $error("bnn_layer_seq: NUM_INPUTS must be a multiple of BEAT_BITS");
    end

    layer_state_t state, state_n;

    logic [BW-1:0]        b_cnt, b_n;
    logic [NW-1:0]        n_cnt, n_n;
    logic                 w_rd_en_n, th_rd_en_n;
    logic [AW-1:0]        w_addr_n;
    logic [NW-1:0]        th_addr_n;
    logic                 in_fire;

    logic [BEAT_BITS-1:0] x_buf [BEATS];

    logic                 d_valid;
    logic [BW-1:0]        d_b;
    logic [NW-1:0]        d_n;
    logic [ACC_W-1:0]     acc;
    logic [ACC_W-1:0]     acc_sum;
    logic [PC_W-1:0]      pc;

    assign in_fire = in_valid && in_ready;

    // Next-state, counter and registered-output logic.
    always_comb begin
        state_n    = state;
        b_n        = b_cnt;
        n_n        = n_cnt;
        w_rd_en_n  = 1'b0;
        w_addr_n   = w_addr;
        th_rd_en_n = 1'b0;
        th_addr_n  = th_addr;

        case (state)
            ST_LOAD: begin
                if (in_fire) begin
                    if (b_cnt == B_LAST) begin
                        state_n    = ST_COMPUTE;
                        b_n        = '0;
                        n_n        = '0;
                        w_rd_en_n  = 1'b1;
                        w_addr_n   = '0;
                        th_rd_en_n = (BEATS == 1);
                        th_addr_n  = '0;
                    end else begin
                        b_n = b_cnt + BW'(1);
                    end
                end
            end
            ST_COMPUTE: begin
                if (b_cnt == B_LAST && n_cnt == N_LAST) begin
                    state_n = ST_DRAIN;
                end else begin
                    if (b_cnt == B_LAST) begin
                        b_n = '0;
                        n_n = n_cnt + NW'(1);
                    end else begin
                        b_n = b_cnt + BW'(1);
                    end
                    w_rd_en_n  = 1'b1;
                    w_addr_n   = AW'(32'(n_n) * BEATS + 32'(b_n));
                    th_rd_en_n = (b_n == B_LAST);
                    th_addr_n  = n_n;
                end
            end
            ST_DRAIN: begin
                state_n = ST_OUTPUT;
                b_n     = '0;
                n_n     = '0;
            end
            ST_OUTPUT: begin
                if (out_ready) begin
                    state_n = ST_LOAD;
                end
            end
            default: begin
                state_n = ST_LOAD;
            end
        endcase
    end

    // State, counters and control outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_LOAD;
            b_cnt     <= '0;
            n_cnt     <= '0;
            w_rd_en   <= 1'b0;
            w_addr    <= '0;
            th_rd_en  <= 1'b0;
            th_addr   <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            b_cnt     <= b_n;
            n_cnt     <= n_n;
            w_rd_en   <= w_rd_en_n;
            w_addr    <= w_addr_n;
            th_rd_en  <= th_rd_en_n;
            th_addr   <= th_addr_n;
            in_ready  <= (state_n == ST_LOAD);
            out_valid <= (state_n == ST_OUTPUT);
            busy      <= (state_n == ST_COMPUTE) || (state_n == ST_DRAIN);
        end
    end

    // Activation buffer; contents are only meaningful after a full load.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            x_buf[b_cnt] <= in_data;
        end
    end

    xnor_popcount #(
        .BEAT_BITS(BEAT_BITS)
    ) u_xnor_popcount (
        .w    (w_rd_data),
        .x    (x_buf[d_b]),
        .count(pc)
    );

    assign acc_sum = (d_b == '0) ? ACC_W'(pc) : acc + ACC_W'(pc);

    // Data stage: one cycle behind issue, accumulates and thresholds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_valid  <= 1'b0;
            d_b      <= '0;
            d_n      <= '0;
            acc      <= '0;
            out_data <= '0;
        end else begin
            d_valid <= w_rd_en;
            d_b     <= b_cnt;
            d_n     <= n_cnt;
            if (d_valid) begin
                acc <= acc_sum;
                if (d_b == B_LAST) begin
                    out_data[d_n] <= (CMP_W'(acc_sum) >= CMP_W'(th_rd_data));
                end
            end
        end
    end

endmodule

// File: doc/bnn_layer_seq.md
# bnn_layer_seq

Time-multiplexed sequencer for one binary fully-connected layer of the BNN core. Buffers one input activation vector, then drives the shared XNOR-popcount datapath through every neuron of the layer, streaming weight beats and one threshold per neuron from external synchronous RAMs. It accumulates the popcount across beats, compares the total against the threshold, and emits the packed activation vector on a valid/ready stream to the next layer.

## Interface
- NUM_INPUTS, 256, input activations per vector; must be a multiple of BEAT_BITS (elaboration-time assertion)
- BEAT_BITS, 64, activation/weight bits per beat; BEATS = NUM_INPUTS/BEAT_BITS
- NUM_NEURONS, 64, neurons in the layer
- THRESHOLD_BITS, 32, unsigned threshold width
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid & in_ready
- in_data  in  BEAT_BITS  activation beat; beat 0 carries inputs [BEAT_BITS-1:0]
- w_rd_en  out  1  weight RAM read strobe
- w_addr  out  $clog2(NUM_NEURONS*BEATS)  = n*BEATS + b
- w_rd_data  in  BEAT_BITS  weight beat, valid the cycle after w_rd_en
- th_rd_en  out  1  threshold RAM read strobe
- th_addr  out  $clog2(NUM_NEURONS)  neuron index n
- th_rd_data  in  THRESHOLD_BITS  threshold, valid the cycle after th_rd_en
- out_valid  out  1  activation vector valid
- out_ready  in  1  downstream accept
- out_data  out  NUM_NEURONS  bit n = activation of neuron n
- busy  out  1  high in COMPUTE and DRAIN

## Operation
- States: LOAD, COMPUTE, DRAIN, OUTPUT. Reset enters LOAD.
- LOAD: in_ready=1; each handshake writes in_data into x buffer slot b (beat counter). Handshake on beat BEATS-1 -> COMPUTE, counters cleared. Gaps in in_valid allowed.
- COMPUTE: one read per cycle, no bubbles: w_rd_en=1, w_addr=n*BEATS+b, b increments, wraps to 0 with n++. th_rd_en=1, th_addr=n only on beat b=BEATS-1. Issue of (n=NUM_NEURONS-1, b=BEATS-1) -> DRAIN.
- Data stage (one cycle behind issue, tracked by registered valid/beat/neuron tags): pc = popcount(w_rd_data ~^ x[b]); on b=0 acc<=pc, else acc<=acc+pc; on b=BEATS-1 out_data[n] <= ((acc_prev+pc) >= th_rd_data) (acc_prev = 0 when BEATS=1).
- acc width $clog2(NUM_INPUTS+1); zero-extended to max(acc width, THRESHOLD_BITS) for an unsigned compare. Threshold 0 -> bit 1; threshold > NUM_INPUTS -> bit 0.
- DRAIN: single cycle completing final data stage -> OUTPUT.
- OUTPUT: out_valid=1, out_data stable; in_ready=0, no RAM reads. Handshake -> LOAD.
- in_ready=1 only in LOAD; out_valid=1 only in OUTPUT. No overlap of load with compute.

## Timing
- Reset values (async, immediate): state LOAD, in_ready=1, out_valid=0, out_data=0, w_rd_en=0, th_rd_en=0, busy=0, all counters and acc=0.
- Reset mid-LOAD/COMPUTE/OUTPUT: partial vector and results discarded, outputs to reset values; RAM data returning after reset is ignored.
- Last input handshake in cycle T: first w_rd_en in T+1; out_valid rises in T+NUM_NEURONS*BEATS+2.
- Minimum vector period: BEATS + NUM_NEURONS*BEATS + 2 cycles (out_ready held high).
- RAM read latency fixed at 1 cycle; w_rd_data/th_rd_data sampled only in the cycle after the matching strobe.

## Structure
- Package bnn_pkg: state enum (LOAD, COMPUTE, DRAIN, OUTPUT) and width helper function for accumulator and counters; shared with other layer blocks.
- Sub-module xnor_popcount (parameter BEAT_BITS): combinational w ~^ x followed by popcount, $clog2(BEAT_BITS+1)-bit output. Sequencer instantiates one.

## Test plan
Parameters NUM_INPUTS=16, BEAT_BITS=8, NUM_NEURONS=4, THRESHOLD_BITS=32 unless stated.
- All weights 8'hFF, input 16'hFFFF, thresholds {16,17,0,8} -> out_data=4'b1101.
- Weights for neuron 2 = 8'h0F/8'h00, input 16'h00FF, threshold 6 -> pc 4+8=12, bit2=1; threshold 13 -> bit2=0.
- Last in handshake at T -> w_addr sequence 0..7 in T+1..T+8, th_addr 0..3 on b=1 cycles, out_valid first high at T+10.
- out_ready low 5 cycles in OUTPUT -> out_valid/out_data stable, in_ready=0, no RAM strobes; handshake -> in_ready=1 next cycle.
- in_valid with 3-cycle gap between beats -> same result as back-to-back input.
- rst pulsed during COMPUTE (n=2) -> outputs at reset values immediately; next full vector yields correct out_data, no stale bits.
